// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: loads 16 message words into the scheduler, then runs 64 rounds per block.
// Optional completed-block counter is enabled by defining SHA256_BLKCNT_EN.
//   state | meaning
//   IDLE  | waiting for word 0 of a new message
//   LOAD  | accepting words 1..15 of the current block
//   ROUND | last load shift, then 64 compression rounds
//   FINAL | one-cycle block wrap-up: chain to the next block or finish the message
module sha256_block_ctrl #(
    parameter int ROUNDS    = 64,
    parameter int BLK_WORDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        abort_i,
    input  logic [31:0] word_in_i,
    input  logic        word_valid_i,
    input  logic        word_last_i,
    output logic        word_ready_o,
    output logic [31:0] sched_data_o,
    output logic        sched_shift_o,
    output logic        flag_0_15_o,
    output logic [6:0]  round_o,
    output logic        round_valid_o,
    output logic        first_blk_o,
    output logic        digest_done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] blk_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;

    localparam logic [3:0] LOAD_LAST  = 4'(BLK_WORDS - 1);
    localparam logic [6:0] ROUND_LAST = 7'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [6:0]  round_q, round_d;
    logic        round_valid_q, round_valid_d;
    logic        first_blk_q, first_blk_d;
    logic        last_blk_q, last_blk_d;
    logic [31:0] sched_data_q, sched_data_d;
    logic        sched_shift_q, sched_shift_d;
    logic        flag_q, flag_d;
    logic        err_q, err_d;
    logic        accept;
    logic        bad_last;

    assign word_ready_o = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !abort_i;
    assign accept       = word_valid_i && word_ready_o;
    assign bad_last     = word_last_i && (load_cnt_q != LOAD_LAST);

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        round_d       = round_q;
        round_valid_d = round_valid_q;
        first_blk_d   = first_blk_q;
        last_blk_d    = last_blk_q;
        sched_data_d  = sched_data_q;
        sched_shift_d = 1'b0;
        flag_d        = flag_q;
        err_d         = 1'b0;

        if (accept && !bad_last) begin
            sched_data_d  = word_in_i;
            sched_shift_d = 1'b1;
            flag_d        = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                first_blk_d = 1'b1;
                load_cnt_d  = '0;
                if (accept) begin
                    if (bad_last) begin
                        err_d = 1'b1;
                    end else begin
                        load_cnt_d = 4'd1;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        last_blk_d = word_last_i;
                        state_d    = S_ROUND;
                    end else if (bad_last) begin
                        err_d      = 1'b1;
                        load_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            S_ROUND: begin
                // First ROUND cycle only lets the word-15 load shift land.
                if (!round_valid_q) begin
                    round_valid_d = 1'b1;
                    round_d       = '0;
                    sched_shift_d = 1'b1;
                    flag_d        = 1'b1;
                end else if (round_q == ROUND_LAST) begin
                    round_valid_d = 1'b0;
                    round_d       = '0;
                    flag_d        = 1'b0;
                    state_d       = S_FINAL;
                end else begin
                    round_d       = round_q + 7'd1;
                    sched_shift_d = 1'b1;
                end
            end
            S_FINAL: begin
                load_cnt_d = '0;
                if (last_blk_q) begin
                    state_d = S_IDLE;
                end else begin
                    first_blk_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d       = S_IDLE;
            load_cnt_d    = '0;
            round_d       = '0;
            round_valid_d = 1'b0;
            first_blk_d   = 1'b1;
            last_blk_d    = 1'b0;
            sched_shift_d = 1'b0;
            flag_d        = 1'b0;
            err_d         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            round_q       <= '0;
            round_valid_q <= 1'b0;
            first_blk_q   <= 1'b1;
            last_blk_q    <= 1'b0;
            sched_data_q  <= '0;
            sched_shift_q <= 1'b0;
            flag_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            round_q       <= round_d;
            round_valid_q <= round_valid_d;
            first_blk_q   <= first_blk_d;
            last_blk_q    <= last_blk_d;
            sched_data_q  <= sched_data_d;
            sched_shift_q <= sched_shift_d;
            flag_q        <= flag_d;
            err_q         <= err_d;
        end
    end

    assign sched_data_o  = sched_data_q;
    assign sched_shift_o = sched_shift_q;
    assign flag_0_15_o   = flag_q;
    assign round_o       = round_q;
    assign round_valid_o = round_valid_q;
    assign first_blk_o   = first_blk_q;
    assign digest_done_o = (state_q == S_FINAL) && last_blk_q && !abort_i;
    assign err_o         = err_q;
    assign busy_o        = (state_q != S_IDLE);

`ifdef SHA256_BLKCNT_EN
    logic [31:0] blk_cnt_q;
    logic        blk_inc;

    // Counts every block that reaches FINAL; abort and err leave it alone.
    assign blk_inc = (state_q == S_FINAL) && !abort_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q <= '0;
        end else if (blk_inc) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_count_o = blk_cnt_q;
`else
    assign blk_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Scoreboard bench for sha256_block_ctrl with a reference SHA-256 message scheduler driven by the DUT.
module tb_sha256_block_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] wd = '0;
    logic        wv = 1'b0;
    logic        wl = 1'b0;
    logic        word_ready, sched_shift, flag, round_valid, first_blk;
    logic        digest_done, err, busy;
    logic [31:0] sched_data, blk_count;
    logic [6:0]  round;

    sha256_block_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .abort_i       (abort),
        .word_in_i     (wd),
        .word_valid_i  (wv),
        .word_last_i   (wl),
        .word_ready_o  (word_ready),
        .sched_data_o  (sched_data),
        .sched_shift_o (sched_shift),
        .flag_0_15_o   (flag),
        .round_o       (round),
        .round_valid_o (round_valid),
        .first_blk_o   (first_blk),
        .digest_done_o (digest_done),
        .err_o         (err),
        .busy_o        (busy),
        .blk_count_o   (blk_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic int blk_exp(input int n);
`ifdef SHA256_BLKCNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Reference scheduler: sm[0] is the oldest word (W[round] during ROUND).
    logic [31:0] sm [16];
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    initial for (int i = 0; i < 16; i++) sm[i] = '0;
    always @(posedge clk) begin
        if (sched_shift) begin
            for (int i = 0; i < 15; i++) sm[i] <= sm[i+1];
            sm[15] <= flag ? (sig1(sm[14]) + sm[9] + sig0(sm[1]) + sm[0]) : sched_data;
        end
    end

    // kind: 0 = end of a round sequence, 1 = digest_done, 2 = err
    typedef struct {
        int          kind;
        int          rounds;
        int          loads;
        int          stalls;
        logic        fb;
        logic        chk63;
        logic [31:0] w0;
        logic [31:0] blk;
    } exp_t;
    exp_t q[$];

    function automatic exp_t mk(input int kind, input int rounds, input int loads, input int stalls,
                                input logic fb, input logic c63, input logic [31:0] w0, input logic [31:0] blk);
        exp_t e;
        e.kind = kind; e.rounds = rounds; e.loads = loads; e.stalls = stalls;
        e.fb = fb; e.chk63 = c63; e.w0 = w0; e.blk = blk;
        return e;
    endfunction

    int          rcnt = 0, rbad = 0, loads = 0, stalls = 0, fbbad = 0;
    logic        fb0 = 1'b0;
    logic        prev_rv = 1'b0;
    logic [6:0]  prev_round = '0;
    logic [31:0] w0c = '0, w63c = '0;

    task automatic clear_mon();
        rcnt = 0; rbad = 0; loads = 0; stalls = 0; fbbad = 0;
    endtask

    task automatic pop(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    task automatic block_end();
        exp_t e; bit ok;
        pop(0, e, ok);
        if (ok) begin
            chk("round_cycles", rcnt, e.rounds);
            chk("round_sequence_errs", rbad, 0);
            chk("load_shifts", loads, e.loads);
            chk("load_stalls", stalls, e.stalls);
            chk("first_blk", int'(fb0), int'(e.fb));
            chk("first_blk_steady", fbbad, 0);
            chk("sched_w0", w0c, e.w0);
            if (e.chk63) chk("sched_w63", w63c, 32'h12B1EDEB);
        end
        clear_mon();
    endtask

    always @(negedge clk) begin
        exp_t e; bit ok;
        if (prev_rv && !round_valid) block_end();
        if (digest_done) begin
            pop(1, e, ok);
            if (ok) begin
                chk("digest_blk_count", blk_count, e.blk);
                chk("digest_after_r63", int'(prev_round), 63);
                chk("digest_err_excl", int'(err), 0);
            end
        end
        if (err) begin
            pop(2, e, ok);
            if (ok) begin
                chk("err_busy", int'(busy), 0);
                chk("err_no_rounds", rcnt, 0);
            end
            clear_mon();
        end
        if (round_valid) begin
            if (rcnt == 0) begin
                fb0 = first_blk;
                w0c = sm[0];
            end else if (first_blk !== fb0) begin
                fbbad++;
            end
            if (round !== rcnt[6:0]) rbad++;
            if (rcnt == 63) w63c = sm[0];
            rcnt++;
        end
        if (busy && word_ready && !round_valid && !wv) stalls++;
        if (sched_shift && !flag) loads++;
        if (!rst_n) clear_mon();
        prev_rv    = round_valid;
        prev_round = round;
    end

    task automatic send(input logic [31:0] d, input logic l);
        bit rdy, acc;
        wd = d; wl = l; wv = 1'b1; acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            rdy = word_ready;
            @(posedge clk);
            #1;
            acc = rdy;
        end
        if (!acc) fail_now("send_timeout");
    endtask

    // abc=1 sends the padded "abc" block; otherwise word i = base + i.
    task automatic send_blk(input logic [31:0] base, input bit abc, input bit last,
                            input int last_idx, input int stall_idx);
        logic [31:0] w;
        for (int i = 0; i <= last_idx; i++) begin
            if (i == stall_idx) begin
                wv = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            if (abc) w = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
            else     w = base + 32'(i);
            send(w, last && (i == last_idx));
        end
        wl = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) fail_now("wait_idle");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input logic [6:0] r);
        bit hit = 1'b0;
        for (int t = 0; t < 400 && !hit; t++) begin
            @(negedge clk);
            hit = round_valid && (round == r);
        end
        if (!hit) fail_now("wait_round");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_word_ready", int'(word_ready), 1);
        chk("rst_round", int'(round), 0);
        chk("rst_round_valid", int'(round_valid), 0);
        chk("rst_first_blk", int'(first_blk), 1);
        chk("rst_digest", int'(digest_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sched_shift", int'(sched_shift), 0);
        chk("rst_blk_count", blk_count, 0);
        rst_n = 1'b1;

        // 1: async reset in the middle of ROUND
        q.push_back(mk(0, 31, 16, 0, 1'b1, 1'b0, 32'h100, 0));
        send_blk(32'h100, 1'b0, 1'b1, 15, -1);
        wv = 1'b0;
        wait_round(7'd30);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_busy", int'(busy), 0);
        chk("t1_round", int'(round), 0);
        chk("t1_word_ready", int'(word_ready), 1);
        chk("t1_round_valid", int'(round_valid), 0);
        chk("t1_digest", int'(digest_done), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 2: single-block "abc"
        q.push_back(mk(0, 64, 16, 0, 1'b1, 1'b1, 32'h61626380, 0));
        q.push_back(mk(1, 0, 0, 0, 1'b0, 1'b0, 0, blk_exp(0)));
        send_blk(32'h0, 1'b1, 1'b1, 15, -1);
        wv = 1'b0;
        chk("t2_rv_lat1", int'(round_valid), 0);
        @(posedge clk);
        #1;
        chk("t2_rv_lat2", int'(round_valid), 1);
        wait_idle();

        // 3: two-block message with a 3-cycle stall at word 7 of block 2
        do_reset();
        q.push_back(mk(0, 64, 16, 0, 1'b1, 1'b0, 32'h200, 0));
        q.push_back(mk(0, 64, 16, 3, 1'b0, 1'b0, 32'h300, 0));
        q.push_back(mk(1, 0, 0, 0, 1'b0, 1'b0, 0, blk_exp(1)));
        send_blk(32'h200, 1'b0, 1'b0, 15, -1);
        send_blk(32'h300, 1'b0, 1'b1, 15, 7);
        wv = 1'b0;
        wait_idle();
        chk("t3_blk_count", blk_count, blk_exp(2));

        // 4: word_last on word 9, then a normal block
        do_reset();
        q.push_back(mk(2, 0, 0, 0, 1'b0, 1'b0, 0, 0));
        q.push_back(mk(0, 64, 16, 0, 1'b1, 1'b0, 32'h400, 0));
        q.push_back(mk(1, 0, 0, 0, 1'b0, 1'b0, 0, blk_exp(0)));
        send_blk(32'h500, 1'b0, 1'b1, 9, -1);
        wv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_busy", int'(busy), 0);
        chk("t4_round_valid", int'(round_valid), 0);
        send_blk(32'h400, 1'b0, 1'b1, 15, -1);
        wv = 1'b0;
        wait_idle();

        // 5: abort at round 10 with a word offered
        do_reset();
        q.push_back(mk(0, 11, 16, 0, 1'b1, 1'b0, 32'h600, 0));
        q.push_back(mk(0, 64, 16, 0, 1'b1, 1'b0, 32'h700, 0));
        q.push_back(mk(1, 0, 0, 0, 1'b0, 1'b0, 0, blk_exp(0)));
        send_blk(32'h600, 1'b0, 1'b1, 15, -1);
        wv = 1'b0;
        wait_round(7'd10);
        #1;
        abort = 1'b1;
        wd = 32'hDEADBEEF;
        wv = 1'b1;
        #1;
        chk("t5_ready_abort", int'(word_ready), 0);
        @(posedge clk);
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_round", int'(round), 0);
        chk("t5_round_valid", int'(round_valid), 0);
        chk("t5_no_shift", int'(sched_shift), 0);
        abort = 1'b0;
        wv = 1'b0;
        send_blk(32'h700, 1'b0, 1'b1, 15, -1);
        wv = 1'b0;
        wait_idle();

        // 6: three-block message
        do_reset();
        q.push_back(mk(0, 64, 16, 0, 1'b1, 1'b0, 32'h800, 0));
        q.push_back(mk(0, 64, 16, 3, 1'b0, 1'b0, 32'h900, 0));
        q.push_back(mk(0, 64, 16, 0, 1'b0, 1'b0, 32'hA00, 0));
        q.push_back(mk(1, 0, 0, 0, 1'b0, 1'b0, 0, blk_exp(2)));
        send_blk(32'h800, 1'b0, 1'b0, 15, -1);
        send_blk(32'h900, 1'b0, 1'b0, 15, 7);
        send_blk(32'hA00, 1'b0, 1'b1, 15, -1);
        wv = 1'b0;
        wait_idle();
        chk("t6_blk_count", blk_count, blk_exp(3));

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
